// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI receiver, its FIFO and the SPI master.
//   spi_byte_t      : one received byte with its command/data flag
//   RD_*            : bit positions of the fields in the readdata word
//   SPI_SAMPLE_RISING : sampling edge (mode 3 samples on the rising sclk edge)
//   ST_*            : receiver FSM state encodings
//   pack_readdata   : assembles the Avalon readdata word from its fields
package spi_pkg;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } spi_byte_t;

    localparam int unsigned RD_DC        = 8;
    localparam int unsigned RD_VALID     = 9;
    localparam int unsigned RD_OVF       = 10;
    localparam int unsigned RD_COUNT_LSB = 16;

    // Mode 3: sclk idles high, data is sampled on the rising edge.
    localparam logic SPI_SAMPLE_RISING = 1'b1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic logic [31:0] pack_readdata(
        input spi_byte_t  head,
        input logic       valid,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] r;
        r                       = '0;
        r[7:0]                  = head.data;
        r[RD_DC]                = head.dc;
        r[RD_VALID]             = valid;
        r[RD_OVF]               = ovf;
        r[RD_COUNT_LSB +: 8]    = count;
        return r;
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// spi_fifo: synchronous FIFO for received SPI bytes.
//   clk, reset  : clock, synchronous active-high reset
//   push_i/din_i: write request and data; accepted when not full, or when a
//                 pop in the same cycle frees the slot
//   pop_i       : read request; ignored while empty
//   drop_o      : push requested but not accepted (FIFO full, no pop)
//   full_o, empty_o, count_o, head_o : status and the current head entry
module spi_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 9,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic          drop_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic [W-1:0]  head_o
);
    import spi_pkg::*;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         pop_ok;
    logic         push_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot the push lands in, so a full
    // FIFO still accepts the push.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/spislave.sv
// spislave: SPI mode-3 receiver with an Avalon-MM readable byte FIFO.
// Samples sclk/mosi/csn/dcn from the master through two-flop synchronizers,
// assembles MSB-first bytes tagged with dcn, and queues them.
//   clk, reset : system clock, synchronous active-high reset
//   sclk, mosi, csn, dcn : SPI inputs, asynchronous to clk
//   read       : pops the FIFO head (no effect while empty)
//   write/writedata : writedata[10]=1 clears the sticky overflow flag
//   readdata   : [7:0] head byte, [8] head dc, [9] valid, [10] overflow,
//                [23:16] FIFO count, zero elsewhere; combinational
module spislave #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        csn,
    input  logic        dcn,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);
    import spi_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    // Synchronizers; reset values match the idle bus (sclk high, csn high).
    logic sclk_m_q, sclk_s_q, sclk_p_q;
    logic csn_m_q,  csn_s_q;
    logic mosi_m_q, mosi_s_q;
    logic dcn_m_q,  dcn_s_q;

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       ovf_q,   ovf_d;

    logic       sclk_edge;
    logic       push;
    spi_byte_t  push_byte;

    logic       fifo_drop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [AW:0] fifo_count;
    logic [8:0] fifo_head;
    spi_byte_t  head_byte;

    logic       unused_wd;
    assign unused_wd = ^{writedata[31:11], writedata[9:0], fifo_full};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_m_q <= 1'b1;
            sclk_s_q <= 1'b1;
            sclk_p_q <= 1'b1;
            csn_m_q  <= 1'b1;
            csn_s_q  <= 1'b1;
            mosi_m_q <= 1'b0;
            mosi_s_q <= 1'b0;
            dcn_m_q  <= 1'b1;
            dcn_s_q  <= 1'b1;
        end else begin
            sclk_m_q <= sclk;
            sclk_s_q <= sclk_m_q;
            sclk_p_q <= sclk_s_q;
            csn_m_q  <= csn;
            csn_s_q  <= csn_m_q;
            mosi_m_q <= mosi;
            mosi_s_q <= mosi_m_q;
            dcn_m_q  <= dcn;
            dcn_s_q  <= dcn_m_q;
        end
    end

    assign sclk_edge = SPI_SAMPLE_RISING ? (sclk_s_q && !sclk_p_q)
                                         : (!sclk_s_q && sclk_p_q);

    assign push_byte = '{dc: dcn_s_q, data: {shift_q, mosi_s_q}};

    // In SHIFT the sampling edge is handled before the csn check, so an edge
    // that coincides with csn rising still completes the byte. A csn rise
    // with a partial byte simply resets the counter; nothing is pushed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!csn_s_q) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclk_edge) begin
                    shift_d = {shift_q[5:0], mosi_s_q};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) push = 1'b1;
                end
                if (csn_s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Set has priority over a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (write && writedata[RD_OVF]) ovf_d = 1'b0;
        if (fifo_drop)                  ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    spi_fifo #(
        .DEPTH (DEPTH),
        .W     (9)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_byte),
        .pop_i   (read),
        .drop_o  (fifo_drop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    // The storage array is not reset, so the head is masked while empty.
    assign head_byte = fifo_empty ? spi_byte_t'('0) : spi_byte_t'(fifo_head);
    assign readdata  = pack_readdata(head_byte, !fifo_empty, ovf_q,
                                     8'(fifo_count));

endmodule
